// File: rtl/sram_arb_ctrl.sv
// Two-requester controller for an 8-bit x 256 asynchronous SRAM: arbitrates, sequences glitch-free strobes, returns ack/rdata.
// Optional macro SRAM_ARB_CTRL_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin arbitration.
module sram_arb_ctrl #(
  parameter int STROBE_CYCLES = 2,
  parameter int AW            = 8,
  parameter int DW            = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          sram_cs,
  output logic          sram_rd,
  output logic          sram_wr,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          op_we;
  logic          op_we_nxt;
  logic          owner;
  logic          owner_nxt;
  logic          grant_any;
  logic          grant_port;
  logic          strobe_last;

  logic          cs_nxt;
  logic          rd_nxt;
  logic          wr_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] din_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          ack0_nxt;
  logic          ack1_nxt;

  assign grant_any   = req0 | req1;
  assign strobe_last = (state == STROBE) && (cnt == 4'd0);
  assign busy        = (state != IDLE);

`ifdef SRAM_ARB_CTRL_FIXED_PRIO_EN
  assign grant_port = ~req0;
`else
  // rr_pref names the port that wins when both request; it moves only on a grant.
  logic rr_pref;

  always_comb begin
    if (req0 && req1) grant_port = rr_pref;
    else              grant_port = ~req0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          rr_pref <= 1'b0;
    else if (state == IDLE && grant_any) rr_pref <= ~grant_port;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = SETUP;
      end
      SETUP: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == 4'd0) state_nxt = HOLD;
        else             cnt_nxt   = cnt - 4'd1;
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next values for every SRAM pin and handshake; all are registered below so the pins never glitch.
  always_comb begin
    cs_nxt    = sram_cs;
    rd_nxt    = sram_rd;
    wr_nxt    = sram_wr;
    addr_nxt  = sram_addr;
    din_nxt   = sram_din;
    rdata_nxt = rdata;
    op_we_nxt = op_we;
    owner_nxt = owner;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          cs_nxt    = 1'b1;
          owner_nxt = grant_port;
          op_we_nxt = grant_port ? we1    : we0;
          addr_nxt  = grant_port ? addr1  : addr0;
          din_nxt   = grant_port ? wdata1 : wdata0;
        end
      end
      SETUP: begin
        if (op_we) wr_nxt = 1'b1;
        else       rd_nxt = 1'b0;
      end
      STROBE: begin
        if (strobe_last) begin
          wr_nxt   = 1'b0;
          rd_nxt   = 1'b1;
          ack0_nxt = ~owner;
          ack1_nxt = owner;
          if (!op_we) rdata_nxt = sram_dout;
        end
      end
      HOLD: begin
        cs_nxt = 1'b0;
      end
      default: begin
        cs_nxt = 1'b0;
        rd_nxt = 1'b1;
        wr_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cs   <= 1'b0;
      sram_rd   <= 1'b1;
      sram_wr   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rdata     <= '0;
      op_we     <= 1'b0;
      owner     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      sram_cs   <= cs_nxt;
      sram_rd   <= rd_nxt;
      sram_wr   <= wr_nxt;
      sram_addr <= addr_nxt;
      sram_din  <= din_nxt;
      rdata     <= rdata_nxt;
      op_we     <= op_we_nxt;
      owner     <= owner_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
    end
  end

endmodule
